// File: rtl/bin_operand_parser.sv
// bin_operand_parser: turns an ASCII stream such as "1010,0111\n" into two
// WIDTH-bit operands with per-operand error flags, handed downstream over a
// valid/ready handshake.
// Optional build macro: LEADING_ZERO_SKIP_EN -- leading '0' digits are
// accepted without counting toward the WIDTH digit limit.
//
// state | meaning
// S_OP1 | shifting digits into operand 1
// S_OP2 | shifting digits into operand 2
// S_OUT | result presented, waiting for out_ready
module bin_operand_parser #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_char,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] op1,
  output logic [WIDTH-1:0] op2,
  output logic             err1,
  output logic             err2,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_1     = 8'h31;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_LF    = 8'h0A;

  typedef enum logic [1:0] {
    S_OP1 = 2'd0,
    S_OP2 = 2'd1,
    S_OUT = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_acc1, r_acc2;
  logic [CW-1:0]    r_cnt1, r_cnt2;
  logic             r_seen1, r_seen2;
  logic             r_err1, r_err2;
  logic [WIDTH-1:0] r_op1, r_op2;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_acc1_nxt, w_acc2_nxt;
  logic [CW-1:0]    w_cnt1_nxt, w_cnt2_nxt;
  logic             w_seen1_nxt, w_seen2_nxt;
  logic             w_err1_nxt, w_err2_nxt;

  // The active operand is selected once so the per-character rules are
  // written a single time and written back to whichever operand is live.
  logic             w_accept;
  logic             w_sel2;
  logic [WIDTH-1:0] w_acc_cur, w_acc_upd;
  logic [CW-1:0]    w_cnt_cur, w_cnt_upd;
  logic             w_seen_cur, w_seen_upd;
  logic             w_err_set;
  logic             w_miss2;

  assign in_ready  = !reset && (r_state != S_OUT);
  assign out_valid = !reset && (r_state == S_OUT);
  assign op1       = r_op1;
  assign op2       = r_op2;
  assign err1      = r_err1;
  assign err2      = r_err2;

  assign w_accept   = in_valid && in_ready;
  assign w_sel2     = (r_state == S_OP2);
  assign w_acc_cur  = w_sel2 ? r_acc2  : r_acc1;
  assign w_cnt_cur  = w_sel2 ? r_cnt2  : r_cnt1;
  assign w_seen_cur = w_sel2 ? r_seen2 : r_seen1;

  // Next-state and per-character operand update.
  always_comb begin
    w_state_nxt = r_state;
    w_acc1_nxt  = r_acc1;
    w_acc2_nxt  = r_acc2;
    w_cnt1_nxt  = r_cnt1;
    w_cnt2_nxt  = r_cnt2;
    w_seen1_nxt = r_seen1;
    w_seen2_nxt = r_seen2;
    w_err1_nxt  = r_err1;
    w_err2_nxt  = r_err2;
    w_acc_upd   = w_acc_cur;
    w_cnt_upd   = w_cnt_cur;
    w_seen_upd  = w_seen_cur;
    w_err_set   = 1'b0;
    w_miss2     = 1'b0;

    case (r_state)
      S_OP1, S_OP2: begin
        if (w_accept) begin
          case (in_char)
            CH_0, CH_1: begin
              if (w_cnt_cur < CNT_MAX) begin
                w_acc_upd  = {w_acc_cur[WIDTH-2:0], in_char[0]};
                w_seen_upd = 1'b1;
`ifdef LEADING_ZERO_SKIP_EN
                if (!((in_char == CH_0) && (w_cnt_cur == '0))) begin
                  w_cnt_upd = w_cnt_cur + CW'(1);
                end
`else
                w_cnt_upd = w_cnt_cur + CW'(1);
`endif
              end else begin
                // too many digits: keep the value, saturate the count
                w_err_set = 1'b1;
              end
            end
            CH_MINUS: w_err_set = 1'b1;
            CH_COMMA: begin
              if (w_sel2) begin
                w_err_set = 1'b1;
              end else begin
                w_err_set   = !w_seen_cur;
                w_state_nxt = S_OP2;
              end
            end
            CH_LF: begin
              w_err_set   = !w_seen_cur;
              w_miss2     = !w_sel2;
              w_state_nxt = S_OUT;
            end
            default: w_err_set = 1'b1;
          endcase
        end

        if (w_sel2) begin
          w_acc2_nxt  = w_acc_upd;
          w_cnt2_nxt  = w_cnt_upd;
          w_seen2_nxt = w_seen_upd;
          w_err2_nxt  = r_err2 | w_err_set;
        end else begin
          w_acc1_nxt  = w_acc_upd;
          w_cnt1_nxt  = w_cnt_upd;
          w_seen1_nxt = w_seen_upd;
          w_err1_nxt  = r_err1 | w_err_set;
          w_err2_nxt  = r_err2 | w_miss2;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          w_state_nxt = S_OP1;
          w_acc1_nxt  = '0;
          w_acc2_nxt  = '0;
          w_cnt1_nxt  = '0;
          w_cnt2_nxt  = '0;
          w_seen1_nxt = 1'b0;
          w_seen2_nxt = 1'b0;
          w_err1_nxt  = 1'b0;
          w_err2_nxt  = 1'b0;
        end
      end
      default: w_state_nxt = S_OP1;
    endcase
  end

  // State and operand registers; result operands latch on entry to S_OUT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_OP1;
      r_acc1  <= '0;
      r_acc2  <= '0;
      r_cnt1  <= '0;
      r_cnt2  <= '0;
      r_seen1 <= 1'b0;
      r_seen2 <= 1'b0;
      r_err1  <= 1'b0;
      r_err2  <= 1'b0;
      r_op1   <= '0;
      r_op2   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc1  <= w_acc1_nxt;
      r_acc2  <= w_acc2_nxt;
      r_cnt1  <= w_cnt1_nxt;
      r_cnt2  <= w_cnt2_nxt;
      r_seen1 <= w_seen1_nxt;
      r_seen2 <= w_seen2_nxt;
      r_err1  <= w_err1_nxt;
      r_err2  <= w_err2_nxt;
      if ((w_state_nxt == S_OUT) && (r_state != S_OUT)) begin
        r_op1 <= w_err1_nxt ? '0 : w_acc1_nxt;
        r_op2 <= w_err2_nxt ? '0 : w_acc2_nxt;
      end
    end
  end

endmodule
